// File: rtl/board_ui_ctrl.sv
// Board user-interface controller: synchronises switches, debounces buttons into
// level/press outputs, and pages a wide status bus onto LEDs with flash and heartbeat.
module board_ui_ctrl #(
   parameter int NUM_BTN      = 2,
   parameter int NUM_SW       = 4,
   parameter int NUM_LED      = 8,
   parameter int NUM_PAGES    = 4,
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int FLASH_CYC    = 50000000,
   parameter int HB_EN        = 1,
   parameter int HB_DIV       = 50000000
) (
   input  logic                           sys_clk,
   input  logic                           rstbtn_n,
   input  logic [NUM_BTN-1:0]             btn,
   input  logic [NUM_SW-1:0]              sw,
   input  logic [NUM_PAGES*NUM_LED-1:0]   status_bus,
   output logic [NUM_BTN-1:0]             btn_level,
   output logic [NUM_BTN-1:0]             btn_press,
   output logic [NUM_SW-1:0]              sw_sync,
   output logic [$clog2(NUM_PAGES)-1:0]   page,
   output logic [NUM_LED-1:0]             led
);

   localparam int PW  = $clog2(NUM_PAGES);
   localparam int DCW = $clog2(DEBOUNCE_CYC);
   localparam int FCW = $clog2(FLASH_CYC + 1);
   localparam int HCW = $clog2(HB_DIV + 1);

   localparam logic [DCW-1:0] DB_MAX     = DCW'(DEBOUNCE_CYC - 1);
   localparam logic [FCW-1:0] FLASH_LOAD = FCW'(FLASH_CYC);
   localparam logic [HCW-1:0] HB_MAX     = HCW'(HB_DIV - 1);
   localparam logic [PW-1:0]  PG_MAX     = PW'(NUM_PAGES - 1);

   logic [NUM_BTN-1:0] r_btn_meta;
   logic [NUM_BTN-1:0] r_btn_sync;
   logic [NUM_BTN-1:0] r_level;
   logic [NUM_BTN-1:0] r_level_d;
   logic [NUM_BTN-1:0] r_press;
   logic [NUM_SW-1:0]  r_sw_meta;
   logic [NUM_SW-1:0]  r_sw_sync;
   logic [DCW-1:0]     r_db_cnt [NUM_BTN];
   logic [PW-1:0]      r_page;
   logic [FCW-1:0]     r_flash_cnt;
   logic [HCW-1:0]     r_hb_cnt;
   logic               r_hb;
   logic [NUM_LED-1:0] r_led;

   logic               w_up;
   logic               w_dn;
   logic               w_page_chg;
   logic [PW-1:0]      w_page_nxt;
   logic [NUM_LED-1:0] w_onehot;
   logic [NUM_LED-1:0] w_led_nxt;

   // Two-flop synchronisers for the asynchronous buttons and switches
   always_ff @(posedge sys_clk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         r_btn_meta <= '0;
         r_btn_sync <= '0;
         r_sw_meta  <= '0;
         r_sw_sync  <= '0;
      end else begin
         r_btn_meta <= btn;
         r_btn_sync <= r_btn_meta;
         r_sw_meta  <= sw;
         r_sw_sync  <= r_sw_meta;
      end
   end

   // Debounce: a pending level is accepted only after it has been stable for the full window
   always_ff @(posedge sys_clk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            r_db_cnt[i] <= '0;
         end
         r_level   <= '0;
         r_level_d <= '0;
         r_press   <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (r_btn_sync[i] == r_level[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_MAX) begin
               r_db_cnt[i] <= '0;
               r_level[i]  <= r_btn_sync[i];
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end

   // Page stepping; simultaneous up and down presses cancel out
   always_comb begin
      w_up       = r_press[1] & ~r_press[0];
      w_dn       = r_press[0] & ~r_press[1];
      w_page_chg = w_up | w_dn;
      w_page_nxt = r_page;
      if (w_up) begin
         if (r_page == PG_MAX) begin
            w_page_nxt = '0;
         end else begin
            w_page_nxt = r_page + 1'b1;
         end
      end else if (w_dn) begin
         if (r_page == '0) begin
            w_page_nxt = PG_MAX;
         end else begin
            w_page_nxt = r_page - 1'b1;
         end
      end else begin
         w_page_nxt = r_page;
      end
   end

   // Page register, flash countdown and free-running heartbeat
   always_ff @(posedge sys_clk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         r_page      <= '0;
         r_flash_cnt <= '0;
         r_hb_cnt    <= '0;
         r_hb        <= 1'b0;
      end else begin
         r_page <= w_page_nxt;
         if (w_page_chg) begin
            r_flash_cnt <= FLASH_LOAD;
         end else if (r_flash_cnt != '0) begin
            r_flash_cnt <= r_flash_cnt - 1'b1;
         end else begin
            r_flash_cnt <= r_flash_cnt;
         end
         if (r_hb_cnt == HB_MAX) begin
            r_hb_cnt <= '0;
            r_hb     <= ~r_hb;
         end else begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
         end
      end
   end

   // LED source select: page number while flashing, otherwise the status slice
   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < NUM_LED; i++) begin
         w_onehot[i] = (int'(r_page) == i);
      end
      w_led_nxt = status_bus[int'(r_page)*NUM_LED +: NUM_LED];
      if (r_flash_cnt != '0) begin
         w_led_nxt = w_onehot;
      end else begin
         w_led_nxt[NUM_LED-1] = (HB_EN != 0) ? r_hb
                                             : status_bus[int'(r_page)*NUM_LED + NUM_LED - 1];
      end
   end

   // Registered LED drive
   always_ff @(posedge sys_clk or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         r_led <= '0;
      end else begin
         r_led <= w_led_nxt;
      end
   end

   assign btn_level = r_level;
   assign btn_press = r_press;
   assign sw_sync   = r_sw_sync;
   assign page      = r_page;
   assign led       = r_led;

endmodule

// File: tb/tb_board_ui_ctrl.sv
// Directed self-checking bench for board_ui_ctrl with short debounce/flash/heartbeat
// periods; expected values are hand-derived cycle by cycle from reset release.
module tb_board_ui_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  btn;
   logic [3:0]  sw;
   logic [31:0] status;
   logic [1:0]  btn_level;
   logic [1:0]  btn_press;
   logic [3:0]  sw_sync;
   logic [1:0]  page;
   logic [7:0]  led;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc;

   board_ui_ctrl #(
      .NUM_BTN(2), .NUM_SW(4), .NUM_LED(8), .NUM_PAGES(4),
      .DEBOUNCE_CYC(4), .FLASH_CYC(8), .HB_EN(1), .HB_DIV(5)
   ) dut (
      .sys_clk(clk), .rstbtn_n(rst_n), .btn(btn), .sw(sw), .status_bus(status),
      .btn_level(btn_level), .btn_press(btn_press), .sw_sync(sw_sync),
      .page(page), .led(led)
   );

   always #5 clk = ~clk;

   // Clock edges since the last reset release; drives the heartbeat expectation
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // hb value after m clock edges: toggles every 5 edges, starting at 0
   function automatic logic hb_at(input int m);
      return ((m / 5) % 2) != 0;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Press a button mask for 10 cycles, release for 10; report press activity
   task automatic press(input logic [1:0] m, output int n_cycles, output logic [1:0] seen);
      n_cycles = 0;
      seen     = 2'b00;
      btn      = m;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) btn = 2'b00;
         step();
         if (btn_press != 2'b00) n_cycles++;
         seen = seen | btn_press;
      end
   endtask

   initial begin
      int         n_p;
      logic [1:0] seen;
      logic [1:0] lvl_any;

      rst_n  = 1'b0;
      btn    = 2'b00;
      sw     = 4'b0000;
      status = 32'hA53C_960F;
      repeat (3) step();
      chk("rst_led",   led,       32'h0);
      chk("rst_page",  page,      32'h0);
      chk("rst_level", btn_level, 32'h0);
      chk("rst_press", btn_press, 32'h0);
      chk("rst_sw",    sw_sync,   32'h0);
      rst_n = 1'b1;

      // Switch synchroniser latency
      sw = 4'b1010;
      step();
      chk("sw_lag1", sw_sync, 32'h0);
      step();
      chk("sw_lag2", sw_sync, 32'hA);

      // Idle heartbeat on led[7], page 0 status below it
      for (int i = 0; i < 12; i++) begin
         step();
         chk("hb_led", led, {hb_at(cyc - 1), 7'h0F});
      end

      // Glitch of 3 cycles is rejected
      lvl_any = 2'b00;
      seen    = 2'b00;
      btn     = 2'b10;
      for (int i = 0; i < 15; i++) begin
         if (i == 3) btn = 2'b00;
         step();
         lvl_any = lvl_any | btn_level;
         seen    = seen | btn_press;
      end
      chk("t1_level", lvl_any, 32'h0);
      chk("t1_press", seen,    32'h0);
      chk("t1_page",  page,    32'h0);

      // Long page-up press: level, pulse, page, flash, then status with heartbeat
      n_p = 0;
      btn = 2'b10;
      for (int i = 1; i <= 20; i++) begin
         step();
         n_p += int'(btn_press[1]);
         if (i == 5) chk("t2_level_pre", btn_level, 32'h0);
         if (i == 6) begin
            chk("t2_level",     btn_level, 32'h2);
            chk("t2_press_pre", btn_press, 32'h0);
         end
         if (i == 7) chk("t2_press", btn_press, 32'h2);
         if (i == 8) begin
            chk("t2_press_off", btn_press, 32'h0);
            chk("t2_page",      page,      32'h1);
         end
         if (i >= 9 && i <= 16) chk("t2_flash", led, 32'h02);
         if (i >= 17) chk("t2_led", led, {hb_at(cyc - 1), 7'h16});
      end
      btn = 2'b00;
      for (int i = 0; i < 10; i++) begin
         step();
         n_p += int'(btn_press[1]);
      end
      chk("t2_npress",  n_p,       32'd1);
      chk("t2_fall",    btn_level, 32'h0);
      chk("t2_page_hold", page,    32'h1);

      // Page down to 0, wrap down to 3, wrap up to 0
      press(2'b01, n_p, seen);
      chk("t3_dn_page", page, 32'h0);
      press(2'b01, n_p, seen);
      chk("t3_wrap_dn", page, 32'h3);
      chk("t3_led_p3",  led,  {hb_at(cyc - 1), 7'h25});
      press(2'b10, n_p, seen);
      chk("t3_wrap_up", page, 32'h0);
      chk("t3_npress",  n_p,  32'd1);

      // Both buttons together: one shared pulse, page and LEDs undisturbed
      n_p  = 0;
      seen = 2'b00;
      btn  = 2'b11;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) btn = 2'b00;
         step();
         if (btn_press != 2'b00) n_p++;
         seen = seen | btn_press;
         chk("t4_noflash", led, {hb_at(cyc - 1), 7'h0F});
      end
      chk("t4_seen",   seen, 32'h3);
      chk("t4_npress", n_p,  32'd1);
      chk("t4_page",   page, 32'h0);

      // Reset mid-flash with page-up held, then recovery
      btn = 2'b10;
      repeat (10) step();
      chk("t6_pre_page", page, 32'h1);
      chk("t6_pre_led",  led,  32'h02);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_led",   led,       32'h0);
      chk("t6_rst_page",  page,      32'h0);
      chk("t6_rst_level", btn_level, 32'h0);
      repeat (3) step();
      rst_n = 1'b1;
      n_p = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         n_p += int'(btn_press[1]);
      end
      chk("t6_npress", n_p,  32'd1);
      chk("t6_page",   page, 32'h1);
      btn = 2'b00;
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
